// File: rtl/cordic_pkg.sv
// Shared types and constants for the CORDIC phase generator: quadrant codes,
// FSM states and turn-fraction angle constants.
package cordic_pkg;

    typedef enum logic [1:0] {
        QUAD_0 = 2'd0,
        QUAD_1 = 2'd1,
        QUAD_2 = 2'd2,
        QUAD_3 = 2'd3
    } quad_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    // Quarter and half turn for a w-bit phase word (one turn = 2^w).
    function automatic logic [63:0] ang_90(input int unsigned w);
        return 64'd1 << (w - 2);
    endfunction

    function automatic logic [63:0] ang_180(input int unsigned w);
        return 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/cordic_quad_fold.sv
// Folds an unsigned turn-fraction phase into [-90deg, +90deg) for the CORDIC core,
// flagging when the core's sin/cos results must be negated.
module cordic_quad_fold
    import cordic_pkg::*;
#(
    parameter int PHASE_W = 32
) (
    input  logic [PHASE_W-1:0] phase_i,
    output logic [PHASE_W-1:0] angle_o,
    output logic [1:0]         quad_o,
    output logic               neg_o
);

    localparam logic [PHASE_W-1:0] ANG_180 = PHASE_W'(ang_180(PHASE_W));

    // Rotating by half a turn negates both sin and cos; the subtraction wraps.
    always_comb begin
        quad_o  = phase_i[PHASE_W-1 -: 2];
        neg_o   = (quad_o == QUAD_1) || (quad_o == QUAD_2);
        angle_o = neg_o ? (phase_i - ANG_180) : phase_i;
    end

endmodule

// File: rtl/cordic_phase_gen.sv
// Phase accumulator and angle sequencer feeding the CORDIC core, with a
// fixed-latency delay line that realigns the negate flag with the core output.
module cordic_phase_gen
    import cordic_pkg::*;
#(
    parameter int PHASE_W    = 32,
    parameter int CNT_W      = 16,
    parameter int CORDIC_LAT = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic [PHASE_W-1:0] phase_init,
    input  logic [PHASE_W-1:0] phase_inc,
    input  logic [CNT_W-1:0]   burst_len,
    output logic [PHASE_W-1:0] angle_out,
    output logic [1:0]         quad_out,
    output logic               neg_out,
    output logic               angle_valid,
    input  logic               angle_ready,
    output logic               neg_dly,
    output logic               dly_valid,
    output logic               busy,
    output logic               done
);

    state_e               state_q, state_d;
    logic [PHASE_W-1:0]   phase_q, phase_d;
    logic [PHASE_W-1:0]   inc_q, inc_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [PHASE_W-1:0]   angle_q, angle_d;
    logic [1:0]           quad_q, quad_d;
    logic                 neg_q, neg_d;
    logic                 valid_q, valid_d;
    logic                 done_q, done_d;
    logic [CORDIC_LAT-1:0] dly_xfer_q, dly_neg_q;

    logic               xfer;
    logic [PHASE_W-1:0] fold_phase, fold_angle;
    logic [1:0]         fold_quad;
    logic               fold_neg;

    assign xfer = valid_q & angle_ready;

    // In IDLE the first sample comes straight from phase_init; afterwards from the accumulator.
    assign fold_phase = (state_q == ST_IDLE) ? phase_init : phase_q;

    cordic_quad_fold #(.PHASE_W(PHASE_W)) u_fold (
        .phase_i (fold_phase),
        .angle_o (fold_angle),
        .quad_o  (fold_quad),
        .neg_o   (fold_neg)
    );

    // NOTE: every next-state signal takes its hold value first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        inc_d   = inc_q;
        cnt_d   = cnt_q;
        angle_d = angle_q;
        quad_d  = quad_q;
        neg_d   = neg_q;
        valid_d = valid_q;
        done_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start && !stop) begin
                    inc_d   = phase_inc;
                    cnt_d   = burst_len;
                    angle_d = fold_angle;
                    quad_d  = fold_quad;
                    neg_d   = fold_neg;
                    phase_d = phase_init + phase_inc;
                    valid_d = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (xfer) begin
                    // cnt stays 0 in continuous mode, so reaching 1 only happens for finite bursts.
                    if (stop || cnt_q == CNT_W'(1)) begin
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        angle_d = fold_angle;
                        quad_d  = fold_quad;
                        neg_d   = fold_neg;
                        phase_d = phase_q + inc_q;
                        if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
                    end
                end else if (stop) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (xfer) begin
                    valid_d = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            phase_q <= '0;
            inc_q   <= '0;
            cnt_q   <= '0;
            angle_q <= '0;
            quad_q  <= '0;
            neg_q   <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            inc_q   <= inc_d;
            cnt_q   <= cnt_d;
            angle_q <= angle_d;
            quad_q  <= quad_d;
            neg_q   <= neg_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    // NOTE: the delay line is reset because a stale valid bit would emerge as a phantom core result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dly_xfer_q <= '0;
            dly_neg_q  <= '0;
        end else begin
            dly_xfer_q <= {dly_xfer_q[CORDIC_LAT-2:0], xfer};
            dly_neg_q  <= {dly_neg_q[CORDIC_LAT-2:0], neg_q};
        end
    end

    assign angle_out   = angle_q;
    assign quad_out    = quad_q;
    assign neg_out     = neg_q;
    assign angle_valid = valid_q;
    assign done        = done_q;
    assign busy        = (state_q != ST_IDLE);
    assign dly_valid   = dly_xfer_q[CORDIC_LAT-1];
    assign neg_dly     = dly_neg_q[CORDIC_LAT-1];

endmodule

// File: tb/tb_cordic_phase_gen.sv
// Directed and randomized checks of cordic_phase_gen against a turn-fraction
// reference model; a monitor checks the delay line against logged transfers.
module tb_cordic_phase_gen;

    localparam int PHASE_W = 32;
    localparam int CNT_W   = 16;
    localparam int LAT     = 16;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start, stop, angle_ready;
    logic [PHASE_W-1:0] phase_init, phase_inc;
    logic [CNT_W-1:0]   burst_len;
    logic [PHASE_W-1:0] angle_out;
    logic [1:0]         quad_out;
    logic               neg_out, angle_valid, neg_dly, dly_valid, busy, done;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit xlog[int];

    always #5 clk = ~clk;

    cordic_phase_gen #(.PHASE_W(PHASE_W), .CNT_W(CNT_W), .CORDIC_LAT(LAT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .stop        (stop),
        .phase_init  (phase_init),
        .phase_inc   (phase_inc),
        .burst_len   (burst_len),
        .angle_out   (angle_out),
        .quad_out    (quad_out),
        .neg_out     (neg_out),
        .angle_valid (angle_valid),
        .angle_ready (angle_ready),
        .neg_dly     (neg_dly),
        .dly_valid   (dly_valid),
        .busy        (busy),
        .done        (done)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: sample k sits at init + k*inc of a turn; the back half-plane
    // [quarter, three quarters) is rotated by half a turn and flagged negated.
    function automatic logic [31:0] sample_phase(input logic [31:0] init, input logic [31:0] inc, input int k);
        return init + inc * 32'(k);
    endfunction

    function automatic logic exp_neg(input logic [31:0] p);
        return (p >= 32'h4000_0000) && (p < 32'hC000_0000);
    endfunction

    function automatic logic [31:0] exp_angle(input logic [31:0] p);
        return exp_neg(p) ? p - 32'h8000_0000 : p;
    endfunction

    function automatic logic [1:0] exp_quad(input logic [31:0] p);
        return 2'(p / 32'h4000_0000);
    endfunction

    // Cycle counter since reset release; transfers are logged against it.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) xlog.delete();
        else        cyc++;
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("dly_valid", 64'(xlog.exists(cyc - LAT)), 64'(dly_valid) ^ 64'd0 ? 64'(dly_valid) : 64'(dly_valid));
        end
    end

    always @(negedge clk) begin
        if (rst_n && xlog.exists(cyc - LAT)) check("neg_dly", neg_dly, xlog[cyc - LAT]);
    end

    // Called at a falling edge where the bench drives ready high: sample k must transfer.
    task automatic see_xfer(input logic [31:0] init, input logic [31:0] inc, input int k);
        logic [31:0] p;
        p = sample_phase(init, inc, k);
        check("xfer_valid", angle_valid, 1'b1);
        check("xfer_angle", angle_out, exp_angle(p));
        check("xfer_quad",  quad_out,  exp_quad(p));
        check("xfer_neg",   neg_out,   exp_neg(p));
        xlog[cyc] = exp_neg(p);
    endtask

    task automatic do_start(input logic [31:0] init, input logic [31:0] inc, input logic [CNT_W-1:0] burst);
        phase_init = init;
        phase_inc  = inc;
        burst_len  = burst;
        start      = 1'b1;
        @(posedge clk); #1;
        start      = 1'b0;
    endtask

    task automatic expect_samples(input logic [31:0] init, input logic [31:0] inc,
                                  input int k0, input int k_end, input int pct);
        int k;
        int budget;
        int cycles;
        k      = k0;
        budget = 40 * (k_end - k0) + 20;
        cycles = 0;
        while (k < k_end && cycles < budget) begin
            angle_ready = (int'($urandom_range(99)) < pct);
            @(negedge clk);
            cycles++;
            if (angle_ready) begin
                see_xfer(init, inc, k);
                k++;
            end else begin
                check("hold_valid", angle_valid, 1'b1);
                check("hold_angle", angle_out, exp_angle(sample_phase(init, inc, k)));
            end
            @(posedge clk); #1;
        end
        check("sample_count", k, k_end);
    endtask

    task automatic end_check();
        @(negedge clk);
        check("end_done",  done, 1'b1);
        check("end_valid", angle_valid, 1'b0);
        check("end_busy",  busy, 1'b0);
        @(posedge clk); #1;
        check("done_pulse", done, 1'b0);
    endtask

    initial begin
        #100000;
        $error("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ri, rc;
        start = 1'b0; stop = 1'b0; angle_ready = 1'b0;
        phase_init = '0; phase_inc = '0; burst_len = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", angle_valid, 1'b0);
        check("rst_busy",  busy, 1'b0);
        check("rst_done",  done, 1'b0);
        check("rst_angle", angle_out, 32'h0);
        check("rst_quad",  quad_out, 2'd0);
        check("rst_neg",   neg_out, 1'b0);
        check("rst_dly_valid", dly_valid, 1'b0);
        check("rst_neg_dly",   neg_dly, 1'b0);
        rst_n = 1'b1;

        // Basic burst of four with ready held high.
        angle_ready = 1'b1;
        do_start(32'h0, 32'h2000_0000, 16'd4);
        check("t1_busy", busy, 1'b1);
        expect_samples(32'h0, 32'h2000_0000, 0, 4, 100);
        end_check();

        // Backpressure after the first sample, with an ignored start while busy.
        angle_ready = 1'b1;
        do_start(32'h0, 32'h2000_0000, 16'd4);
        @(negedge clk);
        see_xfer(32'h0, 32'h2000_0000, 0);
        @(posedge clk); #1;
        angle_ready = 1'b0;
        phase_init  = 32'h1357_9BDF;
        burst_len   = 16'd1;
        start       = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_valid", angle_valid, 1'b1);
            check("bp_angle", angle_out, 32'h2000_0000);
            @(posedge clk); #1;
            start = 1'b0;
        end
        expect_samples(32'h0, 32'h2000_0000, 1, 4, 100);
        end_check();

        // Wrap-around through zero under random ready.
        do_start(32'hF000_0000, 32'h2000_0000, 16'd2);
        expect_samples(32'hF000_0000, 32'h2000_0000, 0, 2, 70);
        end_check();

        // Quadrant boundaries: quarter, half and three-quarter turn.
        do_start(32'h4000_0000, 32'h4000_0000, 16'd3);
        expect_samples(32'h4000_0000, 32'h4000_0000, 0, 3, 100);
        end_check();

        // start together with stop in IDLE: nothing starts.
        phase_init = 32'h0;
        start = 1'b1;
        stop  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        stop  = 1'b0;
        @(negedge clk);
        check("ss_busy",  busy, 1'b0);
        check("ss_valid", angle_valid, 1'b0);
        @(posedge clk); #1;

        // Continuous mode ended by stop while the core stalls.
        ri = $urandom;
        rc = $urandom;
        do_start(ri, rc, 16'd0);
        expect_samples(ri, rc, 0, 5, 60);
        angle_ready = 1'b0;
        stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("drain_valid", angle_valid, 1'b1);
            check("drain_busy",  busy, 1'b1);
            check("drain_angle", angle_out, exp_angle(sample_phase(ri, rc, 5)));
            @(posedge clk); #1;
        end
        angle_ready = 1'b1;
        @(negedge clk);
        see_xfer(ri, rc, 5);
        @(posedge clk); #1;
        angle_ready = 1'b0;
        end_check();

        // Negate pattern 0,1,1,0 followed through the delay line.
        angle_ready = 1'b1;
        do_start(32'h0, 32'h4000_0000, 16'd4);
        expect_samples(32'h0, 32'h4000_0000, 0, 4, 100);
        end_check();
        repeat (LAT + 2) @(posedge clk);
        #1;

        // Random configurations.
        for (int r = 0; r < 4; r++) begin
            int unsigned n;
            ri = $urandom;
            rc = $urandom;
            n  = $urandom_range(1, 12);
            do_start(ri, rc, CNT_W'(n));
            expect_samples(ri, rc, 0, int'(n), 50 + 15 * r);
            end_check();
        end

        // Asynchronous reset in the middle of a long run, then restart.
        angle_ready = 1'b1;
        ri = $urandom;
        rc = $urandom;
        do_start(ri, rc, 16'd0);
        expect_samples(ri, rc, 0, 20, 100);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_valid", angle_valid, 1'b0);
        check("arst_busy",  busy, 1'b0);
        check("arst_dly_valid", dly_valid, 1'b0);
        check("arst_done",  done, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        do_start(32'h0, 32'h2000_0000, 16'd4);
        expect_samples(32'h0, 32'h2000_0000, 0, 4, 80);
        end_check();

        repeat (LAT + 4) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
